// File: rtl/cpu_ctrl_pkg.sv
// Shared constants, state encoding and control bundle for the multicycle CPU controller.
package cpu_ctrl_pkg;

  localparam int unsigned OP_W = 5;
  localparam int unsigned AC_W = 4;

  localparam logic [OP_W-1:0] OP_ADD  = 5'h00;
  localparam logic [OP_W-1:0] OP_SUB  = 5'h01;
  localparam logic [OP_W-1:0] OP_AND  = 5'h02;
  localparam logic [OP_W-1:0] OP_OR   = 5'h03;
  localparam logic [OP_W-1:0] OP_SLT  = 5'h04;
  localparam logic [OP_W-1:0] OP_ADDI = 5'h08;
  localparam logic [OP_W-1:0] OP_LW   = 5'h10;
  localparam logic [OP_W-1:0] OP_SW   = 5'h11;
  localparam logic [OP_W-1:0] OP_BEQ  = 5'h12;
  localparam logic [OP_W-1:0] OP_J    = 5'h14;
  localparam logic [OP_W-1:0] OP_JAL  = 5'h15;
  localparam logic [OP_W-1:0] OP_JR   = 5'h16;
  localparam logic [OP_W-1:0] OP_HALT = 5'h1F;

  localparam logic [AC_W-1:0] ALU_AND = 4'b0000;
  localparam logic [AC_W-1:0] ALU_OR  = 4'b0001;
  localparam logic [AC_W-1:0] ALU_ADD = 4'b0010;
  localparam logic [AC_W-1:0] ALU_SUB = 4'b0110;
  localparam logic [AC_W-1:0] ALU_SLT = 4'b0111;

  localparam logic [1:0] PCS_ALU    = 2'd0;
  localparam logic [1:0] PCS_ALUOUT = 2'd1;
  localparam logic [1:0] PCS_JUMP   = 2'd2;
  localparam logic [1:0] PCS_RS     = 2'd3;

  localparam logic [1:0] ASB_RT     = 2'd0;
  localparam logic [1:0] ASB_FOUR   = 2'd1;
  localparam logic [1:0] ASB_IMM    = 2'd2;
  localparam logic [1:0] ASB_IMM_SH = 2'd3;

  typedef enum logic [3:0] {
    S_RESET,
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_ALU_WB_R,
    S_EXEC_I,
    S_ALU_WB_I,
    S_MEM_ADDR,
    S_MEM_RD,
    S_MEM_WB,
    S_MEM_WR,
    S_BRANCH,
    S_JUMP,
    S_JR,
    S_HALT,
    S_TRAP
  } state_t;

  // Moore part of the control word, registered alongside the state.
  typedef struct packed {
    logic            mem_req;
    logic            mem_write;
    logic            iord;
    logic [1:0]      pc_source;
    logic            alu_src_a;
    logic [1:0]      alu_src_b;
    logic [AC_W-1:0] alu_control;
    logic            reg_dst;
    logic            mem_to_reg;
    logic            jal_select;
    logic            reg_write;
    logic            pc_write;
    logic            branch;
    logic            done;
    logic            halted;
  } ctrl_t;

endpackage

// File: rtl/alu_op_dec.sv
// R-type opcode to ALU operation decoder, shared with the single-cycle decoder.
module alu_op_dec
  import cpu_ctrl_pkg::*;
(
  input  logic [OP_W-1:0] i_op_code,
  output logic [AC_W-1:0] o_alu_control
);

  always_comb begin
    o_alu_control = ALU_ADD;
    case (i_op_code)
      OP_ADD:  o_alu_control = ALU_ADD;
      OP_SUB:  o_alu_control = ALU_SUB;
      OP_AND:  o_alu_control = ALU_AND;
      OP_OR:   o_alu_control = ALU_OR;
      OP_SLT:  o_alu_control = ALU_SLT;
      default: o_alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle CPU sequencing FSM sharing one memory port for instructions and data.
// Define ILLEGAL_OP_TRAP_EN to trap undefined opcodes (adds illegalOp); otherwise they act as NOPs.
module multicycle_controller
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned OPW = OP_W,
  parameter int unsigned ACW = AC_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [OPW-1:0] opCode,
  input  logic           zero,
  input  logic           memReady,
  output logic           memReq,
  output logic           memWrite,
  output logic           iorD,
  output logic           irWrite,
  output logic           pcEn,
  output logic [1:0]     pcSource,
  output logic           aluSrcA,
  output logic [1:0]     aluSrcB,
  output logic [ACW-1:0] aluControl,
  output logic           regDst,
  output logic           memToReg,
  output logic           jalSelect,
  output logic           regWrite,
  output logic           instrDone,
`ifdef ILLEGAL_OP_TRAP_EN
  output logic           illegalOp,
`endif
  output logic           halted
);

  state_t          r_state;
  state_t          w_state_d;
  state_t          w_dispatch;
  ctrl_t           r_ctrl;
  ctrl_t           w_ctrl_d;
  logic            w_legal;
  logic [AC_W-1:0] w_alu_r;
  logic            w_in_fetch;
  logic            w_wr_done;

  alu_op_dec u_alu_op_dec (
    .i_op_code    (opCode),
    .o_alu_control(w_alu_r)
  );

  always_comb begin
    w_dispatch = S_FETCH;
    w_legal    = 1'b1;
    case (opCode)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT: w_dispatch = S_EXEC_R;
      OP_ADDI:                               w_dispatch = S_EXEC_I;
      OP_LW, OP_SW:                          w_dispatch = S_MEM_ADDR;
      OP_BEQ:                                w_dispatch = S_BRANCH;
      OP_J, OP_JAL:                          w_dispatch = S_JUMP;
      OP_JR:                                 w_dispatch = S_JR;
      OP_HALT:                               w_dispatch = S_HALT;
      default:                               w_legal    = 1'b0;
    endcase
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      S_RESET:    w_state_d = S_FETCH;
      S_FETCH:    if (memReady) w_state_d = S_DECODE;
      S_DECODE: begin
        if (w_legal) begin
          w_state_d = w_dispatch;
        end else begin
`ifdef ILLEGAL_OP_TRAP_EN
          w_state_d = S_TRAP;
`else
          w_state_d = S_FETCH;
`endif
        end
      end
      S_EXEC_R:   w_state_d = S_ALU_WB_R;
      S_ALU_WB_R: w_state_d = S_FETCH;
      S_EXEC_I:   w_state_d = S_ALU_WB_I;
      S_ALU_WB_I: w_state_d = S_FETCH;
      S_MEM_ADDR: w_state_d = (opCode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   if (memReady) w_state_d = S_MEM_WB;
      S_MEM_WB:   w_state_d = S_FETCH;
      S_MEM_WR:   if (memReady) w_state_d = S_FETCH;
      S_BRANCH:   w_state_d = S_FETCH;
      S_JUMP:     w_state_d = S_FETCH;
      S_JR:       w_state_d = S_FETCH;
      S_HALT:     w_state_d = S_HALT;
      S_TRAP:     w_state_d = S_TRAP;
      default:    w_state_d = S_RESET;
    endcase
  end

  // Control word for the state being entered; opCode is still valid while leaving DECODE.
  always_comb begin
    w_ctrl_d = '0;
    unique case (w_state_d)
      S_FETCH: begin
        w_ctrl_d.mem_req     = 1'b1;
        w_ctrl_d.alu_src_b   = ASB_FOUR;
        w_ctrl_d.alu_control = ALU_ADD;
      end
      S_DECODE: begin
        w_ctrl_d.alu_src_b   = ASB_IMM_SH;
        w_ctrl_d.alu_control = ALU_ADD;
      end
      S_EXEC_R: begin
        w_ctrl_d.alu_src_a   = 1'b1;
        w_ctrl_d.alu_src_b   = ASB_RT;
        w_ctrl_d.alu_control = w_alu_r;
      end
      S_ALU_WB_R: begin
        w_ctrl_d.reg_dst   = 1'b1;
        w_ctrl_d.reg_write = 1'b1;
        w_ctrl_d.done      = 1'b1;
      end
      S_EXEC_I, S_MEM_ADDR: begin
        w_ctrl_d.alu_src_a   = 1'b1;
        w_ctrl_d.alu_src_b   = ASB_IMM;
        w_ctrl_d.alu_control = ALU_ADD;
      end
      S_ALU_WB_I: begin
        w_ctrl_d.reg_write = 1'b1;
        w_ctrl_d.done      = 1'b1;
      end
      S_MEM_RD: begin
        w_ctrl_d.mem_req = 1'b1;
        w_ctrl_d.iord    = 1'b1;
      end
      S_MEM_WB: begin
        w_ctrl_d.mem_to_reg = 1'b1;
        w_ctrl_d.reg_write  = 1'b1;
        w_ctrl_d.done       = 1'b1;
      end
      S_MEM_WR: begin
        w_ctrl_d.mem_req   = 1'b1;
        w_ctrl_d.mem_write = 1'b1;
        w_ctrl_d.iord      = 1'b1;
      end
      S_BRANCH: begin
        w_ctrl_d.alu_src_a   = 1'b1;
        w_ctrl_d.alu_src_b   = ASB_RT;
        w_ctrl_d.alu_control = ALU_SUB;
        w_ctrl_d.pc_source   = PCS_ALUOUT;
        w_ctrl_d.branch      = 1'b1;
        w_ctrl_d.done        = 1'b1;
      end
      S_JUMP: begin
        w_ctrl_d.pc_source  = PCS_JUMP;
        w_ctrl_d.pc_write   = 1'b1;
        w_ctrl_d.done       = 1'b1;
        w_ctrl_d.reg_write  = (opCode == OP_JAL);
        w_ctrl_d.jal_select = (opCode == OP_JAL);
      end
      S_JR: begin
        w_ctrl_d.pc_source = PCS_RS;
        w_ctrl_d.pc_write  = 1'b1;
        w_ctrl_d.done      = 1'b1;
      end
      S_HALT, S_TRAP: w_ctrl_d.halted = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_RESET;
      r_ctrl  <= '0;
    end else begin
      r_state <= w_state_d;
      r_ctrl  <= w_ctrl_d;
    end
  end

  assign w_in_fetch = (r_state == S_FETCH);
  assign w_wr_done  = (r_state == S_MEM_WR) & memReady;

  assign memReq     = r_ctrl.mem_req;
  assign memWrite   = r_ctrl.mem_write;
  assign iorD       = r_ctrl.iord;
  assign irWrite    = w_in_fetch & memReady;
  assign pcEn       = r_ctrl.pc_write | (r_ctrl.branch & zero) | (w_in_fetch & memReady);
  assign pcSource   = r_ctrl.pc_source;
  assign aluSrcA    = r_ctrl.alu_src_a;
  assign aluSrcB    = r_ctrl.alu_src_b;
  assign aluControl = r_ctrl.alu_control;
  assign regDst     = r_ctrl.reg_dst;
  assign memToReg   = r_ctrl.mem_to_reg;
  assign jalSelect  = r_ctrl.jal_select;
  assign regWrite   = r_ctrl.reg_write;
  assign halted     = r_ctrl.halted;

`ifdef ILLEGAL_OP_TRAP_EN
  assign illegalOp  = (r_state == S_TRAP);
  assign instrDone  = r_ctrl.done | w_wr_done;
`else
  // Undefined opcodes retire as a NOP directly out of DECODE.
  assign instrDone  = r_ctrl.done | w_wr_done | ((r_state == S_DECODE) & ~w_legal);
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: per-cycle expected control words queued by stimulus.
module tb_multicycle_controller;

  typedef struct packed {
    logic       mreq;
    logic       mwr;
    logic       iord;
    logic       irw;
    logic       pcen;
    logic [1:0] pcs;
    logic       asa;
    logic [1:0] asb;
    logic [3:0] aluc;
    logic       rdst;
    logic       m2r;
    logic       jal;
    logic       rw;
    logic       done;
    logic       hlt;
    logic       ill;
  } outs_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] opCode = 5'h00;
  logic       zero = 1'b0;
  logic       memReady = 1'b0;
  logic       memReq, memWrite, iorD, irWrite, pcEn, aluSrcA, regDst, memToReg;
  logic       jalSelect, regWrite, instrDone, halted, ill_act;
  logic [1:0] pcSource, aluSrcB;
  logic [3:0] aluControl;

  outs_t q_exp[$];
  string q_name[$];
  int    checks = 0;
  int    errors = 0;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .opCode    (opCode),
    .zero      (zero),
    .memReady  (memReady),
    .memReq    (memReq),
    .memWrite  (memWrite),
    .iorD      (iorD),
    .irWrite   (irWrite),
    .pcEn      (pcEn),
    .pcSource  (pcSource),
    .aluSrcA   (aluSrcA),
    .aluSrcB   (aluSrcB),
    .aluControl(aluControl),
    .regDst    (regDst),
    .memToReg  (memToReg),
    .jalSelect (jalSelect),
    .regWrite  (regWrite),
    .instrDone (instrDone),
`ifdef ILLEGAL_OP_TRAP_EN
    .illegalOp (ill_act),
`endif
    .halted    (halted)
  );

`ifndef ILLEGAL_OP_TRAP_EN
  assign ill_act = 1'b0;
`endif

  // Hand-written per-state expectations.
  function automatic outs_t e_zero();
    outs_t o = '0;
    return o;
  endfunction
  function automatic outs_t e_fetch(input logic rdy);
    outs_t o = '0;
    o.mreq = 1; o.asb = 2'd1; o.aluc = 4'b0010; o.irw = rdy; o.pcen = rdy;
    return o;
  endfunction
  function automatic outs_t e_decode(input logic nop);
    outs_t o = '0;
    o.asb = 2'd3; o.aluc = 4'b0010; o.done = nop;
    return o;
  endfunction
  function automatic outs_t e_exec(input logic [1:0] asb, input logic [3:0] aluc);
    outs_t o = '0;
    o.asa = 1; o.asb = asb; o.aluc = aluc;
    return o;
  endfunction
  function automatic outs_t e_wb(input logic rdst, input logic m2r);
    outs_t o = '0;
    o.rdst = rdst; o.m2r = m2r; o.rw = 1; o.done = 1;
    return o;
  endfunction
  function automatic outs_t e_mem(input logic wr, input logic rdy);
    outs_t o = '0;
    o.mreq = 1; o.iord = 1; o.mwr = wr; o.done = wr & rdy;
    return o;
  endfunction
  function automatic outs_t e_branch(input logic z);
    outs_t o = '0;
    o.asa = 1; o.aluc = 4'b0110; o.pcs = 2'd1; o.pcen = z; o.done = 1;
    return o;
  endfunction
  function automatic outs_t e_jump(input logic [1:0] pcs, input logic link);
    outs_t o = '0;
    o.pcs = pcs; o.pcen = 1; o.done = 1; o.rw = link; o.jal = link;
    return o;
  endfunction
  function automatic outs_t e_stop(input logic ill);
    outs_t o = '0;
    o.hlt = 1; o.ill = ill;
    return o;
  endfunction

  // One clock cycle: drive inputs just after the edge and queue that cycle's expected outputs.
  task automatic cyc(input logic [4:0] opc, input logic rdy, input logic z, input outs_t e,
                     input string n);
    @(posedge clk);
    #1;
    opCode = opc; memReady = rdy; zero = z;
    q_exp.push_back(e);
    q_name.push_back(n);
  endtask

  task automatic reset_seq();
    @(posedge clk);
    #1 rst_n = 1'b0;
    q_exp.push_back(e_zero()); q_name.push_back("rst_assert");
    cyc(5'h00, 1'b1, 1'b0, e_zero(), "rst_held");
    @(posedge clk);
    #1 rst_n = 1'b1;
    q_exp.push_back(e_zero()); q_name.push_back("s_reset");
  endtask

  // Monitor: every cycle with a pending expectation is compared at the falling edge.
  always @(negedge clk) begin
    outs_t act;
    outs_t e;
    string n;
    if (q_exp.size() > 0) begin
      act = {memReq, memWrite, iorD, irWrite, pcEn, pcSource, aluSrcA, aluSrcB, aluControl,
             regDst, memToReg, jalSelect, regWrite, instrDone, halted, ill_act};
      e = q_exp.pop_front();
      n = q_name.pop_front();
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL %s @%0t: got %b expected %b (mreq mwr iord irw pcen pcs asa asb aluc rdst m2r jal rw done hlt ill)",
                 n, $time, act, e);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [4:0] r_ops [5];
    logic [3:0] r_alu [5];
    r_ops = '{5'h00, 5'h01, 5'h02, 5'h03, 5'h04};
    r_alu = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111};

    reset_seq();

    for (int i = 0; i < 5; i++) begin
      cyc(r_ops[i], 1'b1, 1'b0, e_fetch(1'b1), "r_fetch");
      cyc(r_ops[i], 1'b1, 1'b0, e_decode(1'b0), "r_decode");
      cyc(r_ops[i], 1'b1, 1'b0, e_exec(2'd0, r_alu[i]), "r_exec");
      cyc(r_ops[i], 1'b1, 1'b0, e_wb(1'b1, 1'b0), "r_wb");
    end

    cyc(5'h08, 1'b1, 1'b0, e_fetch(1'b1), "addi_fetch");
    cyc(5'h08, 1'b1, 1'b0, e_decode(1'b0), "addi_decode");
    cyc(5'h08, 1'b1, 1'b0, e_exec(2'd2, 4'b0010), "addi_exec");
    cyc(5'h08, 1'b1, 1'b0, e_wb(1'b0, 1'b0), "addi_wb");

    cyc(5'h10, 1'b1, 1'b0, e_fetch(1'b1), "lw_fetch");
    cyc(5'h10, 1'b1, 1'b0, e_decode(1'b0), "lw_decode");
    cyc(5'h10, 1'b1, 1'b0, e_exec(2'd2, 4'b0010), "lw_addr");
    for (int i = 0; i < 3; i++) cyc(5'h10, 1'b0, 1'b0, e_mem(1'b0, 1'b0), "lw_rd_wait");
    cyc(5'h10, 1'b1, 1'b0, e_mem(1'b0, 1'b1), "lw_rd_ready");
    cyc(5'h10, 1'b1, 1'b0, e_wb(1'b0, 1'b1), "lw_wb");

    cyc(5'h11, 1'b0, 1'b0, e_fetch(1'b0), "sw_fetch_wait");
    cyc(5'h11, 1'b0, 1'b0, e_fetch(1'b0), "sw_fetch_wait");
    cyc(5'h11, 1'b1, 1'b0, e_fetch(1'b1), "sw_fetch");
    cyc(5'h11, 1'b0, 1'b0, e_decode(1'b0), "sw_decode_rdy_ignored");
    cyc(5'h11, 1'b1, 1'b0, e_exec(2'd2, 4'b0010), "sw_addr");
    cyc(5'h11, 1'b0, 1'b0, e_mem(1'b1, 1'b0), "sw_wr_wait");
    cyc(5'h11, 1'b1, 1'b0, e_mem(1'b1, 1'b1), "sw_wr_ready");

    for (int i = 0; i < 2; i++) begin
      logic z;
      z = (i == 0);
      cyc(5'h12, 1'b1, z, e_fetch(1'b1), "beq_fetch");
      cyc(5'h12, 1'b1, z, e_decode(1'b0), "beq_decode");
      cyc(5'h12, 1'b1, z, e_branch(z), z ? "beq_taken" : "beq_not_taken");
    end

    cyc(5'h14, 1'b1, 1'b0, e_fetch(1'b1), "j_fetch");
    cyc(5'h14, 1'b1, 1'b0, e_decode(1'b0), "j_decode");
    cyc(5'h14, 1'b1, 1'b0, e_jump(2'd2, 1'b0), "j_jump");
    cyc(5'h15, 1'b1, 1'b0, e_fetch(1'b1), "jal_fetch");
    cyc(5'h15, 1'b1, 1'b0, e_decode(1'b0), "jal_decode");
    cyc(5'h15, 1'b1, 1'b0, e_jump(2'd2, 1'b1), "jal_jump");
    cyc(5'h16, 1'b1, 1'b0, e_fetch(1'b1), "jr_fetch");
    cyc(5'h16, 1'b1, 1'b0, e_decode(1'b0), "jr_decode");
    cyc(5'h16, 1'b1, 1'b0, e_jump(2'd3, 1'b0), "jr_jump");

    cyc(5'h1E, 1'b1, 1'b0, e_fetch(1'b1), "ill_fetch");
`ifdef ILLEGAL_OP_TRAP_EN
    cyc(5'h1E, 1'b1, 1'b0, e_decode(1'b0), "ill_decode");
    for (int i = 0; i < 3; i++) cyc(5'h00, 1'b1, 1'b0, e_stop(1'b1), "ill_trap");
`else
    cyc(5'h1E, 1'b1, 1'b0, e_decode(1'b1), "ill_decode_nop");
    cyc(5'h00, 1'b0, 1'b0, e_fetch(1'b0), "ill_back_to_fetch");
`endif

    reset_seq();

    // Reset asserted in the middle of a pending write drops memReq without waiting for a clock.
    cyc(5'h11, 1'b1, 1'b0, e_fetch(1'b1), "rst_sw_fetch");
    cyc(5'h11, 1'b1, 1'b0, e_decode(1'b0), "rst_sw_decode");
    cyc(5'h11, 1'b1, 1'b0, e_exec(2'd2, 4'b0010), "rst_sw_addr");
    cyc(5'h11, 1'b0, 1'b0, e_mem(1'b1, 1'b0), "rst_sw_wr_wait");
    @(posedge clk);
    #1 memReady = 1'b0;
    #2 rst_n = 1'b0;
    q_exp.push_back(e_zero()); q_name.push_back("rst_mid_write");
    @(posedge clk);
    #1 rst_n = 1'b1;
    q_exp.push_back(e_zero()); q_name.push_back("rst_release_s_reset");

    cyc(5'h1F, 1'b1, 1'b0, e_fetch(1'b1), "halt_fetch");
    cyc(5'h1F, 1'b1, 1'b0, e_decode(1'b0), "halt_decode");
    for (int i = 0; i < 20; i++) cyc(5'h1F, 1'b1, 1'b1, e_stop(1'b0), "halt_sticky");

    @(negedge clk);
    #1;
    checks++;
    if (q_exp.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q_exp.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
